relax_osc_freq_meter: RTL and testbench

- Digital readout for the relaxation oscillator macro: measures oscillator frequency by counting rising edges of the oscillator output over a fixed gate window of clk cycles.
- The oscillator output is routed from an analog pin into a digital input. The counted result is presented byte-wise on the dedicated outputs for off-chip readout.
- Supports single-shot measurement and continuous measurement, with overflow detection.

---
 rtl/relax_osc_freq_meter.sv | 116 +++++++++++
 tb/tb_relax_osc_freq_meter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relax_osc_freq_meter.sv
// Relaxation-oscillator frequency meter: counts synchronized rising edges of
// osc_in over a 2^GATE_LOG2-cycle gate and exposes the result byte-wise.
module relax_osc_freq_meter #(
  parameter int unsigned GATE_LOG2   = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       osc_in,
  input  logic       start,
  input  logic       continuous,
  input  logic       byte_sel,
  output logic [7:0] count_out,
  output logic       busy,
  output logic       valid,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_LATCH
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GATE_LOG2-1:0]   timer_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_int_q;
  logic [CNT_W-1:0]       result_q;
  logic                   ovf_q;
  logic                   valid_q;
  logic                   done_q;

  logic                   rise;
  logic                   cnt_sat;
  logic [15:0]            result_ext;

  assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign cnt_sat = (cnt_q == '1);

  // Synchronizer and edge detector run in every state so entering GATE
  // never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!ena) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start || continuous) state_q <= S_ARM;
          end
          S_ARM: begin
            timer_q   <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            state_q   <= S_GATE;
          end
          S_GATE: begin
            if (rise) begin
              if (cnt_sat) ovf_int_q <= 1'b1;
              else         cnt_q     <= cnt_q + CNT_W'(1);
            end
            timer_q <= timer_q + GATE_LOG2'(1);
            if (timer_q == '1) state_q <= S_LATCH;
          end
          S_LATCH: begin
            result_q <= cnt_q;
            ovf_q    <= ovf_int_q;
            valid_q  <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= continuous ? S_ARM : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    result_ext = '0;
    result_ext[CNT_W-1:0] = result_q;
  end

  assign count_out = byte_sel ? result_ext[15:8] : result_ext[7:0];
  assign busy      = (state_q != S_IDLE);
  assign valid     = valid_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_relax_osc_freq_meter.sv
// Directed bench for relax_osc_freq_meter: three instances (short gate,
// narrow counter, long gate) share stimulus; each test checks its own instance.
module tb_relax_osc_freq_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic osc_in = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic byte_sel = 1'b0;

  logic [7:0] count_a, count_b, count_c;
  logic busy_a, valid_a, done_a, ovf_a;
  logic busy_b, valid_b, done_b, ovf_b;
  logic busy_c, valid_c, done_c, ovf_c;

  int checks = 0;
  int errors = 0;

  int osc_period = 4;
  int osc_hi = 2;
  logic osc_const = 1'b0;
  int ph = 0;

  relax_osc_freq_meter #(.GATE_LOG2(4), .CNT_W(16), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .continuous(continuous), .byte_sel(byte_sel), .count_out(count_a),
    .busy(busy_a), .valid(valid_a), .done(done_a), .overflow(ovf_a));

  relax_osc_freq_meter #(.GATE_LOG2(4), .CNT_W(3), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .continuous(continuous), .byte_sel(byte_sel), .count_out(count_b),
    .busy(busy_b), .valid(valid_b), .done(done_b), .overflow(ovf_b));

  relax_osc_freq_meter #(.GATE_LOG2(10), .CNT_W(16), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .continuous(continuous), .byte_sel(byte_sel), .count_out(count_c),
    .busy(busy_c), .valid(valid_c), .done(done_c), .overflow(ovf_c));

  always #5 clk = ~clk;

  // Oscillator model: high for osc_hi of every osc_period clk cycles,
  // changing away from the clock edge; osc_period==0 holds osc_const.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (osc_period == 0) begin
        osc_in = osc_const;
      end else begin
        ph = (ph + 1) % osc_period;
        osc_in = (ph < osc_hi);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    byte_sel = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    osc_period = 4; osc_hi = 2;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", count_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    start = 1'b0;
  endtask

  task automatic test_single_shot();
    int first = -1;
    int ndone = 0;
    osc_period = 4; osc_hi = 2;
    do_reset();
    pulse_start();
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (done_a) begin
        ndone++;
        if (first < 0) begin
          first = k;
          checks++; if (count_a !== 8'h04) begin errors++; $display("FAIL single_lo got=%h exp=04", count_a); end
          checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", ovf_a); end
          checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", valid_a); end
          byte_sel = 1'b1;
          #1;
          checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL single_hi got=%h exp=00", count_a); end
          byte_sel = 1'b0;
        end
      end
    end
    checks++; if (first !== 19) begin errors++; $display("FAIL single_latency got=%0d exp=19", first); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy_a); end
  endtask

  task automatic test_saturation();
    bit seen = 0;
    osc_period = 2; osc_hi = 1;
    do_reset();
    pulse_start();
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (done_b) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL sat_timeout got=no_done exp=done"); end
    checks++; if (count_b !== 8'h07) begin errors++; $display("FAIL sat_result got=%h exp=07", count_b); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", ovf_b); end
    checks++; if (count_a !== 8'h08) begin errors++; $display("FAIL wide_result got=%h exp=08", count_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL wide_ovf got=%b exp=0", ovf_a); end
  endtask

  task automatic test_const_high();
    bit seen = 0;
    osc_period = 0; osc_const = 1'b1;
    #20;
    do_reset();
    pulse_start();
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (done_a) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL const_timeout got=no_done exp=done"); end
    checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL const_result got=%h exp=00", count_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL const_ovf got=%b exp=0", ovf_a); end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL const_valid got=%b exp=1", valid_a); end
  endtask

  task automatic test_continuous();
    int last = -1;
    int ndone = 0;
    osc_period = 8; osc_hi = 4;
    do_reset();
    continuous = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (done_a) begin
        if (last >= 0) begin
          checks++; if (k - last !== 18) begin errors++; $display("FAIL cont_period got=%0d exp=18", k - last); end
        end
        checks++; if (count_a !== 8'h02) begin errors++; $display("FAIL cont_result got=%h exp=02", count_a); end
        last = k;
        ndone++;
      end
    end
    checks++; if (ndone !== 3) begin errors++; $display("FAIL cont_done_count got=%0d exp=3", ndone); end
    repeat (5) tick();
    continuous = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_a) ndone++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL cont_drop_done got=%0d exp=1", ndone); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cont_drop_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int ndone = 0;
    osc_period = 4; osc_hi = 2;
    do_reset();
    start = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (done_a) begin
        if (last >= 0) begin
          checks++; if (k - last !== 19) begin errors++; $display("FAIL b2b_period got=%0d exp=19", k - last); end
        end
        last = k;
        ndone++;
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
  endtask

  task automatic test_long_gate();
    bit seen = 0;
    osc_period = 3; osc_hi = 1;
    do_reset();
    repeat ($urandom_range(0, 5)) tick();
    pulse_start();
    for (int k = 0; k < 1100 && !seen; k++) begin
      tick();
      if (done_c) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL long_timeout got=no_done exp=done"); end
    checks++; if (count_c !== 8'h55 && count_c !== 8'h56) begin errors++; $display("FAIL long_lo got=%h exp=55_or_56", count_c); end
    byte_sel = 1'b1;
    #1;
    checks++; if (count_c !== 8'h01) begin errors++; $display("FAIL long_hi got=%h exp=01", count_c); end
    byte_sel = 1'b0;
  endtask

  task automatic test_ena_drop();
    int ndone = 0;
    osc_period = 4; osc_hi = 2;
    do_reset();
    pulse_start();
    repeat (25) tick();
    checks++; if (count_a !== 8'h04) begin errors++; $display("FAIL ena_pre_result got=%h exp=04", count_a); end
    osc_period = 2; osc_hi = 1;
    pulse_start();
    repeat (6) tick();
    ena = 1'b0;
    tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ena_busy got=%b exp=0", busy_a); end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done_a) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL ena_done got=%0d exp=0", ndone); end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL ena_valid got=%b exp=1", valid_a); end
    checks++; if (count_a !== 8'h04) begin errors++; $display("FAIL ena_held got=%h exp=04", count_a); end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_gate();
    int ndone = 0;
    osc_period = 4; osc_hi = 2;
    do_reset();
    pulse_start();
    repeat (25) tick();
    pulse_start();
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL rstmid_count got=%h exp=00", count_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done_a) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_done got=%0d exp=0", ndone); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_saturation();
    test_const_high();
    test_continuous();
    test_back_to_back();
    test_long_gate();
    test_ena_drop();
    test_reset_mid_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
